// File: rtl/pio_reset_sequencer_if.sv
// Avalon-MM master bundle between the reset sequencer and a PIO slave.
interface pio_reset_sequencer_if #(
  parameter int DATA_W = 32
);
  logic [2:0]        avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/pio_reset_sequencer.sv
// Pulses selected PIO output bits via outset/outclear writes, verifying each
// transition by reading the data register back.
module pio_reset_sequencer #(
  parameter int DATA_W = 32,
  parameter int HOLD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   pulse_mask,
  input  logic [HOLD_W-1:0]   hold_cycles,
  output logic                busy,
  output logic                done,
  output logic                error,
  pio_reset_sequencer_if.master avm
);

  typedef enum logic [2:0] {IDLE, SET, RD_SET, HOLD, CLR, RD_CLR, DONE} state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] mask, mask_d;
  logic [HOLD_W-1:0] hold, hold_d;
  logic [HOLD_W-1:0] cnt, cnt_d;
  logic              rd2, rd2_d;
  logic              err_d;
  logic [2:0]        addr_d;
  logic              cs_d, wn_d;
  logic [DATA_W-1:0] wd_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      mask               <= '0;
      hold               <= '0;
      cnt                <= '0;
      rd2                <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      avm.avm_address    <= '0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_writedata  <= '0;
    end else begin
      state              <= state_d;
      mask               <= mask_d;
      hold               <= hold_d;
      cnt                <= cnt_d;
      rd2                <= rd2_d;
      busy               <= (state_d != IDLE);
      done               <= (state_d == DONE);
      error              <= err_d;
      avm.avm_address    <= addr_d;
      avm.avm_chipselect <= cs_d;
      avm.avm_write_n    <= wn_d;
      avm.avm_writedata  <= wd_d;
    end
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    state_d = state;
    mask_d  = mask;
    hold_d  = hold;
    cnt_d   = cnt;
    rd2_d   = 1'b0;
    err_d   = error;
    unique case (state)
      IDLE: if (start) begin
        err_d   = 1'b0;
        mask_d  = pulse_mask;
        hold_d  = hold_cycles;
        state_d = (pulse_mask == '0) ? DONE : SET;
      end
      SET: if (!avm.avm_waitrequest) state_d = RD_SET;
      RD_SET: begin
        if (rd2) begin
          if ((avm.avm_readdata & mask) != mask) err_d = 1'b1;
          cnt_d   = (hold == '0) ? '0 : hold - 1'b1;
          state_d = HOLD;
        end else begin
          rd2_d = 1'b1;
        end
      end
      HOLD: begin
        if (abort || cnt == '0) state_d = CLR;
        else                    cnt_d   = cnt - 1'b1;
      end
      CLR: if (!avm.avm_waitrequest) state_d = RD_CLR;
      RD_CLR: begin
        if (rd2) begin
          if ((avm.avm_readdata & mask) != '0) err_d = 1'b1;
          state_d = DONE;
        end else begin
          rd2_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    addr_d = 3'd0;
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    wd_d   = '0;
    unique case (state_d)
      SET: begin
        addr_d = 3'd4;
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        wd_d   = mask_d;
      end
      CLR: begin
        addr_d = 3'd5;
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        wd_d   = mask_d;
      end
      RD_SET, RD_CLR: cs_d = 1'b1;
      default: ;
    endcase
  end

endmodule
